// File: rtl/update_knn8_topk_insert_if.sv
// Bundle of the control, sample-stream and read-port signals of update_knn8_topk_insert.
//   master : driver side (issues start/samples, reads the list back)
//   slave  : the top-K block itself
//   start/n_samples       run control
//   in_valid/in_ready     sample handshake carrying in_dist/in_label
//   busy/done             run status
//   rd_idx -> rd_dist/rd_label (registered), min_dist/min_label (direct)
interface update_knn8_topk_insert_if #(
  parameter int unsigned KNN_K   = 8,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LABEL_W = 4,
  parameter int unsigned CNT_W   = 16
);
  localparam int unsigned IdxW = $clog2(KNN_K);

  logic               start;
  logic [CNT_W-1:0]   n_samples;
  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  in_dist;
  logic [LABEL_W-1:0] in_label;
  logic               busy;
  logic               done;
  logic [IdxW-1:0]    rd_idx;
  logic [DATA_W-1:0]  rd_dist;
  logic [LABEL_W-1:0] rd_label;
  logic [DATA_W-1:0]  min_dist;
  logic [LABEL_W-1:0] min_label;

  modport master (
    output start, n_samples, in_valid, in_dist, in_label, rd_idx,
    input  in_ready, busy, done, rd_dist, rd_label, min_dist, min_label
  );

  modport slave (
    input  start, n_samples, in_valid, in_dist, in_label, rd_idx,
    output in_ready, busy, done, rd_dist, rd_label, min_dist, min_label
  );
endinterface

// File: rtl/update_knn8_topk_insert.sv
// Keeps the KNN_K smallest (distance, label) pairs seen during a run, sorted ascending, by
// single-cycle parallel compare-and-shift insertion. Entry 0 holds the smallest distance.
//   clk, reset : clock and asynchronous active-high reset
//   bus        : slave side of update_knn8_topk_insert_if (control, sample stream, read port)
module update_knn8_topk_insert #(
  parameter int unsigned KNN_K   = 8,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LABEL_W = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  update_knn8_topk_insert_if.slave     bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   n_lat_q, n_lat_d;
  logic [DATA_W-1:0]  dist_q  [KNN_K];
  logic [DATA_W-1:0]  dist_d  [KNN_K];
  logic [LABEL_W-1:0] label_q [KNN_K];
  logic [LABEL_W-1:0] label_d [KNN_K];
  logic [DATA_W-1:0]  rd_dist_q, rd_dist_d;
  logic [LABEL_W-1:0] rd_label_q, rd_label_d;

  logic             in_ready;
  logic             accept;
  logic [KNN_K-1:0] le;

  assign in_ready = (state_q == StRun) && !bus.start && (count_q != n_lat_q);
  assign accept   = bus.in_valid && in_ready;

  // The list is sorted, so le is a thermometer code: entries below the insertion point are set.
  always_comb begin
    le = '0;
    for (int unsigned i = 0; i < KNN_K; i++) begin
      le[i] = (dist_q[i] <= bus.in_dist);
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    n_lat_d    = n_lat_q;
    dist_d     = dist_q;
    label_d    = label_q;
    rd_dist_d  = dist_q[bus.rd_idx];
    rd_label_d = label_q[bus.rd_idx];

    if (bus.start) begin
      state_d = StRun;
      count_d = '0;
      n_lat_d = bus.n_samples;
      for (int unsigned i = 0; i < KNN_K; i++) begin
        dist_d[i]  = '1;
        label_d[i] = '0;
      end
    end else if (state_q == StRun) begin
      if (accept) begin
        count_d = count_q + CNT_W'(1);
        // Keep entries at or below the insertion point, drop the sample in at the first
        // larger entry, shift the rest up by one; the old last entry falls off.
        dist_d[0]  = le[0] ? dist_q[0]  : bus.in_dist;
        label_d[0] = le[0] ? label_q[0] : bus.in_label;
        for (int unsigned i = 1; i < KNN_K; i++) begin
          if (le[i]) begin
            dist_d[i]  = dist_q[i];
            label_d[i] = label_q[i];
          end else if (le[i-1]) begin
            dist_d[i]  = bus.in_dist;
            label_d[i] = bus.in_label;
          end else begin
            dist_d[i]  = dist_q[i-1];
            label_d[i] = label_q[i-1];
          end
        end
      end else if (count_q == n_lat_q) begin
        state_d = StDone;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      count_q    <= '0;
      n_lat_q    <= '0;
      rd_dist_q  <= '1;
      rd_label_q <= '0;
      for (int unsigned i = 0; i < KNN_K; i++) begin
        dist_q[i]  <= '1;
        label_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      n_lat_q    <= n_lat_d;
      rd_dist_q  <= rd_dist_d;
      rd_label_q <= rd_label_d;
      dist_q     <= dist_d;
      label_q    <= label_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.busy      = (state_q == StRun);
  assign bus.done      = (state_q == StDone);
  assign bus.rd_dist   = rd_dist_q;
  assign bus.rd_label  = rd_label_q;
  assign bus.min_dist  = dist_q[0];
  assign bus.min_label = label_q[0];

endmodule

// File: tb/tb_update_knn8_topk_insert.sv
// Randomised and directed bench for update_knn8_topk_insert against a sorted-queue model.
module tb_update_knn8_topk_insert;
  localparam int unsigned K = 8;
  localparam logic [31:0] AllOnes = 32'hFFFF_FFFF;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  l;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  update_knn8_topk_insert_if bus ();

  update_knn8_topk_insert dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: run state plus the K best entries as a sorted queue.
  ent_t        m_list[$];
  int          m_state;  // 0 idle, 1 run, 2 done
  int unsigned m_cnt;
  int unsigned m_nlat;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    ent_t e;
    e.d = AllOnes;
    e.l = 4'd0;
    m_list.delete();
    for (int i = 0; i < K; i++) m_list.push_back(e);
  endfunction

  function automatic void model_insert(input logic [31:0] d, input logic [3:0] l);
    ent_t e;
    int   p = 0;
    e.d = d;
    e.l = l;
    foreach (m_list[i]) if (m_list[i].d <= d) p++;
    if (p < K) begin
      m_list.insert(p, e);
      void'(m_list.pop_back());
    end
  endfunction

  // One clock with optional sample; checks status and min outputs before the edge.
  task automatic cycle(input bit v, input logic [31:0] d, input logic [3:0] l);
    bit exp_rdy;
    bus.in_valid = v;
    bus.in_dist  = d;
    bus.in_label = l;
    exp_rdy = (m_state == 1) && (m_cnt != m_nlat);
    #1;
    check_eq("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
    check_eq("busy", 64'(bus.busy), 64'(m_state == 1));
    check_eq("done", 64'(bus.done), 64'(m_state == 2));
    check_eq("min_dist", 64'(bus.min_dist), 64'(m_list[0].d));
    check_eq("min_label", 64'(bus.min_label), 64'(m_list[0].l));
    @(posedge clk);
    #1;
    if (v && exp_rdy) begin
      model_insert(d, l);
      m_cnt++;
    end else if (m_state == 1 && m_cnt == m_nlat) begin
      m_state = 2;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic do_start(input int unsigned n, input bit v);
    bus.start     = 1'b1;
    bus.n_samples = 16'(n);
    bus.in_valid  = v;
    bus.in_dist   = 32'd1;
    bus.in_label  = 4'd7;
    #1;
    check_eq("start_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    model_clear();
    m_cnt   = 0;
    m_nlat  = n;
    m_state = 1;
  endtask

  task automatic read_sweep();
    for (int i = 0; i < K; i++) begin
      bus.rd_idx = 3'(i);
      cycle(1'b0, 32'd0, 4'd0);
      check_eq($sformatf("rd_dist[%0d]", i), 64'(bus.rd_dist), 64'(m_list[i].d));
      check_eq($sformatf("rd_label[%0d]", i), 64'(bus.rd_label), 64'(m_list[i].l));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check_eq({tag, "_done"}, 64'(bus.done), 64'd0);
    check_eq({tag, "_ready"}, 64'(bus.in_ready), 64'd0);
    check_eq({tag, "_min_dist"}, 64'(bus.min_dist), 64'(AllOnes));
    check_eq({tag, "_min_label"}, 64'(bus.min_label), 64'd0);
    check_eq({tag, "_rd_dist"}, 64'(bus.rd_dist), 64'(AllOnes));
    check_eq({tag, "_rd_label"}, 64'(bus.rd_label), 64'd0);
  endtask

  initial begin
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.n_samples = '0;
    bus.in_valid  = 1'b0;
    bus.in_dist   = '0;
    bus.in_label  = '0;
    bus.rd_idx    = '0;
    model_clear();
    m_state = 0;
    m_cnt   = 0;
    m_nlat  = 0;
    #12;
    check_reset_outputs("reset");
    reset = 1'b0;
    @(posedge clk);
    #1;
    cycle(1'b0, 32'd0, 4'd0);

    // 1: basic sort of three samples
    do_start(3, 1'b0);
    cycle(1'b1, 32'd30, 4'd1);
    cycle(1'b1, 32'd10, 4'd2);
    cycle(1'b1, 32'd20, 4'd3);
    check_eq("t1_ready_after_last", 64'(bus.in_ready), 64'd0);
    check_eq("t1_done_early", 64'(bus.done), 64'd0);
    cycle(1'b0, 32'd0, 4'd0);
    check_eq("t1_done", 64'(bus.done), 64'd1);
    check_eq("t1_min_dist", 64'(bus.min_dist), 64'd10);
    check_eq("t1_min_label", 64'(bus.min_label), 64'd2);
    read_sweep();

    // 2: descending stream, two largest fall off
    do_start(10, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 32'(100 - i), 4'(i));
    cycle(1'b0, 32'd0, 4'd0);
    check_eq("t2_min_dist", 64'(bus.min_dist), 64'd91);
    check_eq("t2_min_label", 64'(bus.min_label), 64'd9);
    read_sweep();
    check_eq("t2_last_dist", 64'(bus.rd_dist), 64'd98);
    check_eq("t2_last_label", 64'(bus.rd_label), 64'd2);

    // 3: ties keep arrival order
    do_start(3, 1'b0);
    cycle(1'b1, 32'd5, 4'd1);
    cycle(1'b1, 32'd5, 4'd2);
    cycle(1'b1, 32'd5, 4'd3);
    cycle(1'b0, 32'd0, 4'd0);
    check_eq("t3_min_label", 64'(bus.min_label), 64'd1);
    read_sweep();

    // 4: zero-sample run
    do_start(0, 1'b0);
    check_eq("t4_busy", 64'(bus.busy), 64'd1);
    cycle(1'b1, 32'd3, 4'd1);
    check_eq("t4_done", 64'(bus.done), 64'd1);
    cycle(1'b1, 32'd2, 4'd2);
    check_eq("t4_min_dist", 64'(bus.min_dist), 64'(AllOnes));

    // 5: restart mid-run with a colliding sample, then reset mid-run
    do_start(8, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'(40 + i), 4'(i));
    do_start(2, 1'b1);
    check_eq("t5_cleared", 64'(bus.min_dist), 64'(AllOnes));
    cycle(1'b1, 32'd7, 4'd3);
    cycle(1'b1, 32'd6, 4'd4);
    cycle(1'b0, 32'd0, 4'd0);
    check_eq("t5_done", 64'(bus.done), 64'd1);
    check_eq("t5_min_dist", 64'(bus.min_dist), 64'd6);
    do_start(5, 1'b0);
    cycle(1'b1, 32'd9, 4'd9);
    reset = 1'b1;
    #1;
    check_reset_outputs("t5_async_reset");
    #2;
    reset = 1'b0;
    model_clear();
    m_state = 0;
    m_cnt   = 0;
    m_nlat  = 0;
    @(posedge clk);
    #1;
    cycle(1'b0, 32'd0, 4'd0);

    // 6: long random run with gaps and frequent ties
    do_start(1000, 1'b0);
    for (int c = 0; c < 5000 && m_state != 2; c++) begin
      bit          v;
      logic [31:0] d;
      v = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       d = 32'($urandom_range(0, 50));
        1:       d = AllOnes;
        default: d = $urandom;
      endcase
      cycle(v, d, 4'($urandom_range(0, 9)));
    end
    check_eq("t6_done", 64'(bus.done), 64'd1);
    check_eq("t6_count", 64'(m_cnt), 64'd1000);
    read_sweep();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
